// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the RV32I fetch stage
package instr_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
  localparam int          FETCH_WIDTH      = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with push/pop/flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full buffer is legal alongside it.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I fetch stage: PC, credit-limited imem requests, decoder buffer
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] out_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_sum;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  entry_in;

  // Buffered words plus in-flight requests never exceed the buffer, so responses always fit.
  assign credit_sum     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_next       = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign push           = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign pop            = instr_valid && instr_ready;
  assign instr_valid    = !fifo_empty;
  assign instr          = head.word;
  assign instr_pc       = head.pc;
  assign entry_in       = '{pc: rsp_pc, word: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (entry_in),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc      <= word_align(redirect_pc);
        rsp_pc  <= word_align(redirect_pc);
        discard <= out_next;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_rsp_valid) begin
          if (discard != '0) discard <= discard - CW'(1);
          else               rsp_pc  <= rsp_pc + 32'd4;
        end
      end
    end
  end

endmodule
